// File: rtl/hilo_md_ctrl_pkg.sv
// hilo_md_ctrl_pkg: EX-stage op codes and multiply/divide sequencer state encoding
package hilo_md_ctrl_pkg;
  localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_DIV = 2'd1, MD_FIX = 2'd2} mdState_t;
endpackage

// File: rtl/hilo_md_ctrl_div_iter.sv
// div_iter: unsigned restoring divider, one quotient bit per cycle, start/abort/done handshake
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);
  localparam int CW = $clog2(WIDTH);
  logic run;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0] shifted, trial;
  assign shifted = {rem, quot[WIDTH-1]};
  assign trial = shifted - {1'b0, dvs};
  assign done = run & (cnt == CW'(WIDTH - 1));
  // quot doubles as the dividend shift register; a borrow out of the trial subtract means restore
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run <= 1'b0;
      cnt <= '0;
      dvs <= '0;
      quot <= '0;
      rem <= '0;
    end else if (abort) begin
      run <= 1'b0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      dvs <= divisor;
      quot <= dividend;
      rem <= '0;
    end else if (run) begin
      quot <= {quot[WIDTH-2:0], ~trial[WIDTH]};
      rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      cnt <= cnt + 1'b1;
      run <= ~done;
    end
  end
endmodule

// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: HI/LO owner with one-cycle MULT commit, MTHI/MTLO and an optional iterative divider (HILO_DIV_EN)
module hilo_md_ctrl
  import hilo_md_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         op_i,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               busy_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               dz_o
);
  logic go, isMult, hiWe, loWe;
  logic [WIDTH-1:0] hiNext, loNext;
  assign go = valid_i & ~flush_i;
  assign isMult = (op_i == EXE_MULT_OP) | (op_i == EXE_MULTU_OP);
`ifdef HILO_DIV_EN
  mdState_t state, nextState;
  logic isDiv, isSigned, divStart, divAbort, divDone, fixWr, qNeg, rNeg, dzDiv;
  logic [WIDTH-1:0] aMag, bMag, quot, rem;
  assign isDiv = (op_i == EXE_DIV_OP) | (op_i == EXE_DIVU_OP);
  assign isSigned = op_i == EXE_DIV_OP;
  assign aMag = (isSigned & a_i[WIDTH-1]) ? -a_i : a_i;
  assign bMag = (isSigned & b_i[WIDTH-1]) ? -b_i : b_i;
  assign fixWr = (state == MD_FIX) & ~flush_i;
  assign busy_o = state != MD_IDLE;
  assign dz_o = fixWr & dzDiv;
  // sequencer: flush aborts a running divide and releases the stall at once; FIX always returns to IDLE
  always_comb begin
    divStart = (state == MD_IDLE) & go & isDiv;
    divAbort = (state == MD_DIV) & flush_i;
    stall_o = divStart | ((state == MD_DIV) & ~flush_i);
    nextState = divStart ? MD_DIV : ((state == MD_DIV) & ~flush_i) ? (divDone ? MD_FIX : MD_DIV) : MD_IDLE;
  end
  // state register plus result sign and divide-by-zero flags captured at start
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= MD_IDLE;
      qNeg <= 1'b0;
      rNeg <= 1'b0;
      dzDiv <= 1'b0;
    end else begin
      state <= nextState;
      if (divStart) begin
        qNeg <= isSigned & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        rNeg <= isSigned & a_i[WIDTH-1];
        dzDiv <= b_i == '0;
      end
    end
  end
  div_iter #(.WIDTH(WIDTH)) uDiv (
    .clk(clk),
    .resetn(resetn),
    .start(divStart),
    .abort(divAbort),
    .dividend(aMag),
    .divisor(bMag),
    .done(divDone),
    .quot(quot),
    .rem(rem)
  );
`else
  logic unusedDivOperand;
  assign unusedDivOperand = ^b_i;
  assign stall_o = 1'b0;
  assign busy_o = 1'b0;
  assign dz_o = 1'b0;
`endif
  // HI/LO write select: single-cycle ops while idle, sign-fixed divide result in FIX
  always_comb begin
    hiWe = go & (isMult | (op_i == EXE_MTHI_OP));
    loWe = go & (isMult | (op_i == EXE_MTLO_OP));
    hiNext = isMult ? prod_i[2*WIDTH-1:WIDTH] : a_i;
    loNext = isMult ? prod_i[WIDTH-1:0] : a_i;
`ifdef HILO_DIV_EN
    if (state != MD_IDLE) begin
      hiWe = fixWr;
      loWe = fixWr;
      hiNext = rNeg ? -rem : rem;
      loNext = qNeg ? -quot : quot;
    end
`endif
  end
  // HI/LO registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_o <= '0;
      lo_o <= '0;
    end else begin
      if (hiWe) hi_o <= hiNext;
      if (loWe) lo_o <= loNext;
    end
  end
endmodule

// File: doc/hilo_md_ctrl.md
# hilo_md_ctrl

Multiply/divide sequencer and HI/LO register owner for the EX stage. Commits the ALU's combinational `hilo_temp` product for MULT/MULTU in one cycle. Runs an iterative restoring divider for DIV/DIVU, stalling the pipeline while it works. Handles MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits.

Ports:
- `clk` (in, 1): clock; single clock domain.
- `resetn` (in, 1): asynchronous, active-low reset.
- `op_i` (in, 8): EX-stage ALU op code (`EXE_*_OP` encoding).
- `valid_i` (in, 1): EX-stage instruction valid.
- `a_i` (in, `WIDTH`): rs operand.
- `b_i` (in, `WIDTH`): rt operand.
- `prod_i` (in, 2*`WIDTH`): ALU `hilo_temp`, already sign-corrected for MULT.
- `flush_i` (in, 1): exception/branch flush of the EX-stage instruction.
- `stall_o` (out, 1): hold IF through EX; combinational.
- `busy_o` (out, 1): state ≠ IDLE.
- `hi_o` (out, `WIDTH`): HI register.
- `lo_o` (out, `WIDTH`): LO register.
- `dz_o` (out, 1): one-cycle pulse; a divide with `b_i == 0` completed.

## Operation
- States: IDLE, DIV, FIX.
- `go` = `valid_i & ~flush_i`.
- IDLE:
  - MULT/MULTU & `go`: {HI,LO} ← `prod_i` at the clock edge.
  - MTHI & `go`: HI ← `a_i`. MTLO & `go`: LO ← `a_i`.
  - DIV/DIVU & `go`: latch `|a|`, `|b|` (magnitudes only for DIV), `qneg = a[31]^b[31]`, `rneg = a[31]` (both 0 for DIVU), `dz = (b_i==0)`. Clear remainder and counter. Go to DIV.
  - Other ops: no HI/LO effect.
- DIV, one quotient bit per cycle:
  - r' = {r, dividend MSB}; if r' ≥ divisor, subtract and shift in 1, else shift in 0.
  - Counter runs 0..`WIDTH`-1; on the last count go to FIX.
- FIX: LO ← `qneg` ? −Q : Q; HI ← `rneg` ? −R : R. Pulse `dz_o` if `dz`. Go to IDLE.
- Arithmetic is `WIDTH`+1-bit for the trial subtract; magnitudes are unsigned `WIDTH` bits, so 0x80000000 is representable.
- Divide by zero runs the full algorithm: raw Q = all ones, raw R = |a|, then sign fix-up. No trap.
- `flush_i` has priority over every other input:
  - In DIV: abort to IDLE; HI/LO unchanged; `dz_o` not pulsed.
  - In FIX: suppress the HI/LO write; go to IDLE.
  - In IDLE: suppresses any write or start.
- Reset mid-division: immediate return to IDLE; HI, LO and all internal registers go to 0.

## Timing
- Reset values: `hi_o`=0, `lo_o`=0, `stall_o`=0, `busy_o`=0, `dz_o`=0; state IDLE.
- MULT/MTHI/MTLO: no stall; new HI/LO visible the cycle after EX.
- MFHI/MFLO in that next cycle reads the updated value; the EX→MEM write and MFHI are sequential, with no bypass needed.
- DIV with the op presented in cycle 0:
  - `stall_o`=1 in cycles 0..32 (33 cycles).
  - In IDLE, `stall_o` = DIV/DIVU & `go`, combinationally.
  - In DIV, `stall_o`=1 unconditionally, unless `flush_i` is high.
  - FIX is cycle 33 with `stall_o`=0, so the div instruction leaves EX on that edge.
  - HI/LO are updated at the end of cycle 33 and visible in cycle 34.
- Total latency: 34 cycles. FIX returns to IDLE, so the same div is never restarted.
- A second div in cycle 34 starts immediately; back-to-back throughput is one div per 34 cycles.
- A flush while `stall_o`=1 drops `stall_o` in the same cycle, combinationally from `flush_i`.

## Configuration
- `HILO_DIV_EN` defined: iterative divider present as above.
- `HILO_DIV_EN` undefined:
  - DIV/DIVU are treated as no-ops: HI/LO unchanged, no stall, `dz_o` tied 0.
  - DIV and FIX states and the datapath are not synthesized; `busy_o` tied 0.

## Structure
- Shared package or defines: `EXE_MULT_OP`, `EXE_MULTU_OP`, `EXE_DIV_OP`, `EXE_DIVU_OP`, `EXE_MTHI_OP`, `EXE_MTLO_OP` (existing `EXE_*_OP` codes), plus the state encoding `MD_IDLE`/`MD_DIV`/`MD_FIX` (2 bits).
- One sub-module, `div_iter`: the shift/subtract datapath and counter, with `start`/`abort`/`done` handshake. The control FSM and HI/LO registers stay in `hilo_md_ctrl`.

## Test plan
- MULT a=0xFFFFFFFE, b=3, `prod_i`=0xFFFFFFFF_FFFFFFFA → next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA; `stall_o` never high.
- DIV a=−7, b=2 → `stall_o` high exactly 33 cycles; cycle 34 LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=0xFFFFFFFF, b=0x10 → LO=0x0FFFFFFF, HI=0xF. DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU a=5, b=0 → LO=0xFFFFFFFF, HI=5, `dz_o` pulses 1 cycle in FIX.
- DIV started, `flush_i` at DIV cycle 10 → `stall_o` drops the same cycle, state IDLE next cycle, HI/LO keep their prior values.
- `resetn` low at DIV cycle 20 → all outputs 0 asynchronously. After release, MTLO a=0x1234 → LO=0x1234 next cycle.
